// File: rtl/param_elastic_pipe.sv
// Elastic multi-lane register pipeline: CHANNELS x WIDTH lanes share one valid/ready handshake over DEPTH stages.
// Latency: DEPTH cycles from in_valid to out_valid when the pipe ahead is empty and unstalled; 1 word/cycle throughput.
// Backpressure: empty stages always refill from upstream, so bubbles collapse; in_ready drops only when every stage is full and out_ready=0, or during flush.
module param_elastic_pipe #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 3,
    parameter int CNT_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          occupancy
);

    // Lane c occupies bits [c*WIDTH +: WIDTH], identical to the flat port mapping.
    typedef logic [CHANNELS-1:0][WIDTH-1:0] word_t;

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    word_t            d [DEPTH];
    logic [CNT_W-1:0] occ;
    logic             accept;
    logic             pop;

    // Ready chain runs from the output back to the input: a stage may move
    // on if the next one is empty or is itself moving on this cycle.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = v[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = v[i] & (~v[i+1] | adv[i+1]);
        end
    end

    assign load     = ~v | adv;
    assign in_ready = load[0] & ~flush;
    assign accept   = in_valid & in_ready;
    assign pop      = adv[DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            if (load[0]) begin
                v[0] <= accept;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (load[i]) begin
                    v[i] <= adv[i-1];
                end
            end
        end
    end

    // Data moves with the valid bits but is not cleared by flush; stale
    // contents are harmless because the valid bits gate them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else begin
            if (accept) begin
                d[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i-1]) begin
                    d[i] <= d[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else if (flush) begin
            occ <= '0;
        end else if (accept && !pop) begin
            occ <= occ + CNT_W'(1);
        end else if (pop && !accept) begin
            occ <= occ - CNT_W'(1);
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign occupancy = occ;

endmodule

// File: tb/tb_param_elastic_pipe.sv
// Checks a default and an overridden param_elastic_pipe against a queue-based model of words in flight.
module tb_param_elastic_pipe;

    logic clk;
    logic rst_n;

    // Default instance: WIDTH=4, CHANNELS=2, DEPTH=3
    logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [7:0]  s_in_data, s_out_data;
    logic [1:0]  s_occ;

    // Overridden instance: WIDTH=8, CHANNELS=3, DEPTH=5
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [23:0] b_in_data, b_out_data;
    logic [2:0]  b_occ;

    localparam int S_DEPTH = 3;
    localparam int B_DEPTH = 5;

    param_elastic_pipe u_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (s_flush),
        .in_data   (s_in_data),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .out_data  (s_out_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .occupancy (s_occ)
    );

    param_elastic_pipe #(.WIDTH(8), .CHANNELS(3), .DEPTH(5), .CNT_W(3)) u_big (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (b_flush),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .occupancy (b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: words in flight, oldest first, each tagged with the cycle it entered stage 0.
    // The oldest word reaches the last stage DEPTH-1 cycles after entry, since nothing is ahead of it.
    typedef struct {
        logic [23:0] dat;
        int          t;
    } ent_t;

    ent_t sq[$];
    ent_t bq[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic logic s_exp_ov();
        return (sq.size() > 0) && ((cyc - sq[0].t) >= S_DEPTH - 1);
    endfunction

    function automatic logic b_exp_ov();
        return (bq.size() > 0) && ((cyc - bq[0].t) >= B_DEPTH - 1);
    endfunction

    // Any empty stage lets the ready chain reach the input, so only a full pipe can block it.
    function automatic logic s_exp_ir();
        return !s_flush && ((sq.size() < S_DEPTH) || s_out_ready);
    endfunction

    function automatic logic b_exp_ir();
        return !b_flush && ((bq.size() < B_DEPTH) || b_out_ready);
    endfunction

    // Called at a negedge with inputs already driven; checks, clocks one edge, updates the model.
    task automatic step();
        logic s_acc, s_pop, b_acc, b_pop;
        ent_t e;
        #1;
        chk("s_occupancy", 32'(s_occ), 32'(sq.size()));
        chk("s_in_ready", 32'(s_in_ready), 32'(s_exp_ir()));
        chk("s_out_valid", 32'(s_out_valid), 32'(s_exp_ov()));
        if (s_exp_ov()) chk("s_out_data", 32'(s_out_data), 32'(sq[0].dat[7:0]));
        chk("b_occupancy", 32'(b_occ), 32'(bq.size()));
        chk("b_in_ready", 32'(b_in_ready), 32'(b_exp_ir()));
        chk("b_out_valid", 32'(b_out_valid), 32'(b_exp_ov()));
        if (b_exp_ov()) chk("b_out_data", 32'(b_out_data), 32'(bq[0].dat));
        s_acc = s_in_valid && s_exp_ir();
        s_pop = s_exp_ov() && s_out_ready;
        b_acc = b_in_valid && b_exp_ir();
        b_pop = b_exp_ov() && b_out_ready;
        @(posedge clk);
        cyc++;
        if (s_pop) void'(sq.pop_front());
        if (s_flush) sq.delete();
        else if (s_acc) begin
            e.dat = 24'(s_in_data);
            e.t   = cyc;
            sq.push_back(e);
        end
        if (b_pop) void'(bq.pop_front());
        if (b_flush) bq.delete();
        else if (b_acc) begin
            e.dat = b_in_data;
            e.t   = cyc;
            bq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle_s(input int n, input logic rdy);
        s_in_valid  = 1'b0;
        s_out_ready = rdy;
        for (int i = 0; i < n; i++) step();
    endtask

    // Holds a word on the small instance until the model says it is taken.
    task automatic push_s(input logic [7:0] dat);
        int n;
        n          = 0;
        s_in_data  = dat;
        s_in_valid = 1'b1;
        while (!s_exp_ir() && n < 20) begin
            step();
            n++;
        end
        total++;
        assert (n < 20) else begin
            bad++;
            $error("FAIL push_timeout observed=%0d expected=<20", n);
        end
        step();
        s_in_valid = 1'b0;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_s_out_valid"}, 32'(s_out_valid), 32'd0);
        chk({tag, "_s_out_data"}, 32'(s_out_data), 32'd0);
        chk({tag, "_s_occ"}, 32'(s_occ), 32'd0);
        chk({tag, "_s_in_ready"}, 32'(s_in_ready), 32'd1);
        chk({tag, "_b_out_valid"}, 32'(b_out_valid), 32'd0);
        chk({tag, "_b_out_data"}, 32'(b_out_data), 32'd0);
        chk({tag, "_b_occ"}, 32'(b_occ), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        s_flush     = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_out_ready = 1'b1;
        b_flush     = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_out_ready = 1'b1;
        #1;
        reset_check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: single word through an empty pipe
        s_in_data  = 8'hA5;
        s_in_valid = 1'b1;
        step();
        idle_s(5, 1'b1);

        // Streaming back-to-back
        s_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_in_data  = 8'(i);
            s_in_valid = 1'b1;
            step();
        end
        idle_s(4, 1'b1);

        // Stall to full, then release
        s_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_s(8'h10 + 8'(i));
        s_in_data  = 8'h13;
        s_in_valid = 1'b1;
        step();
        step();
        chk("full_occ", 32'(s_occ), 32'd3);
        chk("full_hold", 32'(s_out_data), 32'h10);
        s_out_ready = 1'b1;
        push_s(8'h13);
        idle_s(6, 1'b1);

        // Bubble collapse under stall
        s_out_ready = 1'b0;
        push_s(8'h20);
        idle_s(2, 1'b0);
        push_s(8'h21);
        idle_s(2, 1'b0);
        chk("bubble_occ", 32'(s_occ), 32'd2);
        idle_s(4, 1'b1);

        // Flush with a word presented, and flush racing a pop
        s_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_s(8'h28 + 8'(i));
        s_flush    = 1'b1;
        s_in_data  = 8'h30;
        s_in_valid = 1'b1;
        step();
        s_flush    = 1'b0;
        s_in_valid = 1'b0;
        step();
        chk("flush_occ", 32'(s_occ), 32'd0);
        for (int i = 0; i < 3; i++) push_s(8'h40 + 8'(i));
        s_out_ready = 1'b1;
        s_flush     = 1'b1;
        step();
        s_flush = 1'b0;
        idle_s(4, 1'b1);

        // Override instance: lane 2 passes through, then saturate under stall
        b_in_data  = {8'hC3, 16'($urandom)};
        b_in_valid = 1'b1;
        idle_s(0, 1'b1);
        step();
        b_in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        b_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_in_data  = 24'($urandom);
            b_in_valid = 1'b1;
            step();
        end
        chk("b_saturate", 32'(b_occ), 32'd5);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 7; i++) step();

        // Refill both, then asynchronous reset between edges
        s_out_ready = 1'b0;
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) push_s(8'h50 + 8'(i));
        b_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        reset_check("async");
        sq.delete();
        bq.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic on both instances
        for (int i = 0; i < 400; i++) begin
            s_in_data   = 8'($urandom);
            s_in_valid  = ($urandom % 4) != 0;
            s_out_ready = ($urandom % 3) != 0;
            s_flush     = ($urandom % 29) == 0;
            b_in_data   = 24'($urandom);
            b_in_valid  = ($urandom % 3) != 0;
            b_out_ready = ($urandom % 4) == 0;
            b_flush     = ($urandom % 37) == 0;
            step();
        end
        s_flush     = 1'b0;
        b_flush     = 1'b0;
        s_in_valid  = 1'b0;
        b_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        b_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
